// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI flash master: register bit positions,
// FSM state encoding and the default divider-field width.
package spi_master_pkg;

    localparam int DIV_W_DEF    = 3;

    localparam int CTRL_SEL     = 0;
    localparam int CTRL_DIV_LSB = 1;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_RXV     = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_WCOL    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer: while running, emits a one-cycle tick every 2^div_i clk
// cycles. Held at zero when not running, so each transfer starts a fresh period.
module spi_sck_gen
    import spi_master_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    localparam int CNT_W = (1 << DIV_W) - 1;

    logic [CNT_W-1:0] cnt_q, cnt_d, lim;

    // Terminal count 2^div-1 as a thermometer mask of div ones.
    always_comb begin
        for (int i = 0; i < CNT_W; i++) begin
            lim[i] = (i < int'(div_i));
        end
    end

    assign tick_o = run_i && (cnt_q == lim);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!run_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// CPU-programmable SPI mode-0 master for a serial flash: CTRL/STAT/DATA
// registers, one byte per transfer, MSB first, with RX overrun and write-collision flags.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] spireg_d_i,
    output logic [7:0] spireg_d_o,
    input  logic       spireg_wr_i,
    input  logic       spireg_rd_i,
    input  logic       spireg_cs_ctrl_i,
    input  logic       spireg_cs_stat_i,
    input  logic       spireg_cs_data_i,
    output logic       spi_sck_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       spi_cs_n_o
);

    logic             ready_q;
    logic [DIV_W:0]   ctrl_q, ctrl_d;
    logic [DIV_W-1:0] div_q, div_d;
    spi_state_e       state_q, state_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_q, tx_d, rxsh_q, rxsh_d, rx_q, rx_d;
    logic             sck_q, sck_d, mosi_q, mosi_d;
    logic             rxv_q, rxv_d, ovr_q, ovr_d, wcol_q, wcol_d;
    logic             tick, busy, done;
    logic             wr_ctrl, wr_stat, wr_data, rd_data;

    // CPU strobes are ignored until the first edge after reset release.
    assign wr_ctrl = ready_q && spireg_wr_i && spireg_cs_ctrl_i;
    assign wr_stat = ready_q && spireg_wr_i && spireg_cs_stat_i;
    assign wr_data = ready_q && spireg_wr_i && spireg_cs_data_i;
    assign rd_data = ready_q && spireg_rd_i && spireg_cs_data_i;

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_HI) && tick && (bit_q == 3'd7);

    spi_sck_gen #(.DIV_W(DIV_W)) u_sck_gen (
        .clk    (clk),
        .resetn (resetn),
        .run_i  (busy),
        .div_i  (div_q),
        .tick_o (tick)
    );

    always_comb begin
        ctrl_d  = wr_ctrl ? spireg_d_i[DIV_W:0] : ctrl_q;
        div_d   = div_q;
        state_d = state_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rxsh_d  = rxsh_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        rxv_d   = rxv_q;
        ovr_d   = ovr_q;
        wcol_d  = wcol_q;

        unique case (state_q)
            ST_IDLE: begin
                if (wr_data) begin
                    state_d = ST_LO;
                    tx_d    = spireg_d_i;
                    mosi_d  = spireg_d_i[7];
                    div_d   = ctrl_q[DIV_W:CTRL_DIV_LSB];
                    bit_d   = 3'd0;
                end
            end
            ST_LO: begin
                if (tick) begin
                    state_d = ST_HI;
                    sck_d   = 1'b1;
                    rxsh_d  = {rxsh_q[6:0], spi_miso_i};
                end
            end
            ST_HI: begin
                if (tick) begin
                    sck_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_IDLE;
                        bit_d   = 3'd0;
                        rx_d    = rxsh_q;
                    end else begin
                        state_d = ST_LO;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = {tx_q[6:0], 1'b0};
                        mosi_d  = tx_q[6];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A completion wins over a same-edge read: the reader got the old byte.
        if (done) begin
            rxv_d = 1'b1;
        end else if (rd_data) begin
            rxv_d = 1'b0;
        end

        if (done && rxv_q && !rd_data) begin
            ovr_d = 1'b1;
        end else if (wr_stat && spireg_d_i[STAT_OVR]) begin
            ovr_d = 1'b0;
        end

        if (wr_data && busy) begin
            wcol_d = 1'b1;
        end else if (wr_stat && spireg_d_i[STAT_WCOL]) begin
            wcol_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            ctrl_q  <= '0;
            div_q   <= '0;
            state_q <= ST_IDLE;
            bit_q   <= 3'd0;
            tx_q    <= 8'h00;
            rxsh_q  <= 8'h00;
            rx_q    <= 8'h00;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            rxv_q   <= 1'b0;
            ovr_q   <= 1'b0;
            wcol_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            state_q <= state_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rxsh_q  <= rxsh_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            rxv_q   <= rxv_d;
            ovr_q   <= ovr_d;
            wcol_q  <= wcol_d;
        end
    end

    always_comb begin
        spireg_d_o = 8'h00;
        if (spireg_cs_ctrl_i) begin
            spireg_d_o[DIV_W:0] = ctrl_q;
        end else if (spireg_cs_stat_i) begin
            spireg_d_o[STAT_BUSY] = busy;
            spireg_d_o[STAT_RXV]  = rxv_q;
            spireg_d_o[STAT_OVR]  = ovr_q;
            spireg_d_o[STAT_WCOL] = wcol_q;
        end else if (spireg_cs_data_i) begin
            spireg_d_o = rx_q;
        end
    end

    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_n_o = ~ctrl_q[CTRL_SEL];

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with MISO looped back to MOSI; expected
// values are hand-computed from the register map and transfer timing.
module tb_spi_master;

    localparam int CTRL = 0;
    localparam int STAT = 1;
    localparam int DATA = 2;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] d_i, d_o;
    logic       wr, rd, cs_ctrl, cs_stat, cs_data;
    logic       sck, mosi, miso, cs_n;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    assign miso = mosi;
    always #10 clk = ~clk;

    spi_master #(.DIV_W(3)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .spireg_d_i       (d_i),
        .spireg_d_o       (d_o),
        .spireg_wr_i      (wr),
        .spireg_rd_i      (rd),
        .spireg_cs_ctrl_i (cs_ctrl),
        .spireg_cs_stat_i (cs_stat),
        .spireg_cs_data_i (cs_data),
        .spi_sck_o        (sck),
        .spi_mosi_o       (mosi),
        .spi_miso_i       (miso),
        .spi_cs_n_o       (cs_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sel_cs(input int sel);
        cs_ctrl = (sel == CTRL);
        cs_stat = (sel == STAT);
        cs_data = (sel == DATA);
    endtask

    task automatic wr_reg(input int sel, input logic [7:0] v);
        d_i = v;
        wr  = 1'b1;
        sel_cs(sel);
        @(negedge clk);
        wr  = 1'b0;
        d_i = 8'h00;
        sel_cs(-1);
    endtask

    task automatic rd_reg(input int sel, output logic [7:0] v);
        rd = 1'b1;
        sel_cs(sel);
        #1 v = d_o;
        @(negedge clk);
        rd = 1'b0;
        sel_cs(-1);
    endtask

    // Sample once per cycle while STAT.BUSY is set, up to maxc cycles.
    task automatic watch(input int maxc, output int bc, output int fh, output int hc,
                         output int rs, output bit fin, output bit csl);
        logic prev;
        bc = 0; fh = -1; hc = 0; rs = 0; fin = 1'b0; csl = 1'b1; prev = 1'b0;
        cs_stat = 1'b1;
        for (int k = 0; k < maxc; k++) begin
            #1;
            if (!d_o[0]) begin
                fin = 1'b1;
                break;
            end
            bc++;
            if (sck) begin
                hc++;
                if (fh < 0) fh = k;
                if (!prev) rs++;
            end
            prev = sck;
            if (cs_n !== 1'b0) csl = 1'b0;
            @(negedge clk);
        end
        cs_stat = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int bc, fh, hc, rs;
        bit fin, csl;

        resetn = 1'b0;
        d_i = 8'h00; wr = 1'b0; rd = 1'b0;
        cs_ctrl = 1'b0; cs_stat = 1'b0; cs_data = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_csn", cs_n, 1'b1);
        rd_reg(STAT, v); check("rst_stat", v, 8'h00);
        rd_reg(CTRL, v); check("rst_ctrl", v, 8'h00);
        rd_reg(DATA, v); check("rst_data", v, 8'h00);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // DIV=0 loopback of A5
        wr_reg(CTRL, 8'h01);
        check("t1_csn", cs_n, 1'b0);
        rd_reg(CTRL, v); check("t1_ctrl", v, 8'h01);
        wr_reg(DATA, 8'hA5);
        watch(2000, bc, fh, hc, rs, fin, csl);
        check("t1_fin", fin, 1'b1);
        check("t1_busy_cyc", bc, 16);
        check("t1_first_hi", fh, 1);
        check("t1_hi_cyc", hc, 8);
        check("t1_pulses", rs, 8);
        rd_reg(STAT, v); check("t1_stat_rxv", v, 8'h02);
        rd_reg(DATA, v); check("t1_data", v, 8'hA5);
        rd_reg(STAT, v); check("t1_stat_clr", v, 8'h00);

        // DIV=3: 8-cycle half period, 128 busy cycles
        wr_reg(CTRL, 8'h07);
        wr_reg(DATA, 8'h3C);
        watch(2000, bc, fh, hc, rs, fin, csl);
        check("t2_fin", fin, 1'b1);
        check("t2_busy_cyc", bc, 128);
        check("t2_first_hi", fh, 8);
        check("t2_hi_cyc", hc, 64);
        check("t2_pulses", rs, 8);
        check("t2_csn_low", csl, 1'b1);
        rd_reg(STAT, v); check("t2_stat", v, 8'h02);

        // Second transfer over an unread byte -> overrun
        wr_reg(CTRL, 8'h01);
        wr_reg(DATA, 8'h5A);
        watch(2000, bc, fh, hc, rs, fin, csl);
        check("t3_fin", fin, 1'b1);
        check("t3_busy_cyc", bc, 16);
        rd_reg(STAT, v); check("t3_stat_ovr", v, 8'h06);
        rd_reg(DATA, v); check("t3_data", v, 8'h5A);
        rd_reg(STAT, v); check("t3_stat_rd", v, 8'h04);
        wr_reg(STAT, 8'h04);
        rd_reg(STAT, v); check("t3_stat_clr", v, 8'h00);

        // Collision write and mid-transfer DIV change are both ignored by the shifter
        wr_reg(DATA, 8'hC3);
        wr_reg(DATA, 8'h11);
        wr_reg(CTRL, 8'h07);
        watch(2000, bc, fh, hc, rs, fin, csl);
        check("t4_fin", fin, 1'b1);
        check("t4_busy_rest", bc, 14);
        rd_reg(STAT, v); check("t4_stat_wcol", v, 8'h0A);
        rd_reg(CTRL, v); check("t4_ctrl", v, 8'h07);
        rd_reg(DATA, v); check("t4_data", v, 8'hC3);
        wr_reg(STAT, 8'h08);
        rd_reg(STAT, v); check("t4_stat_clr", v, 8'h00);

        // DATA read landing on the completion edge
        wr_reg(CTRL, 8'h01);
        wr_reg(DATA, 8'h81);
        watch(2000, bc, fh, hc, rs, fin, csl);
        check("t5_fin", fin, 1'b1);
        wr_reg(DATA, 8'h7E);
        repeat (15) @(negedge clk);
        rd_reg(DATA, v); check("t5_old_byte", v, 8'h81);
        rd_reg(STAT, v); check("t5_stat", v, 8'h02);
        rd_reg(DATA, v); check("t5_new_byte", v, 8'h7E);
        rd_reg(STAT, v); check("t5_stat_clr", v, 8'h00);

        // Reset during the 5th bit of F8 (SCK high, MOSI=1)
        wr_reg(CTRL, 8'h07);
        wr_reg(DATA, 8'hF8);
        watch(75, bc, fh, hc, rs, fin, csl);
        check("t6_mid_fin", fin, 1'b0);
        check("t6_mid_pulses", rs, 5);
        check("t6_mid_sck", sck, 1'b1);
        check("t6_mid_mosi", mosi, 1'b1);
        resetn = 1'b0;
        #1;
        check("t6_rst_sck", sck, 1'b0);
        check("t6_rst_csn", cs_n, 1'b1);
        check("t6_rst_mosi", mosi, 1'b0);
        rd_reg(STAT, v); check("t6_rst_stat", v, 8'h00);
        rd_reg(CTRL, v); check("t6_rst_ctrl", v, 8'h00);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        wr_reg(CTRL, 8'h01);
        wr_reg(DATA, 8'h96);
        watch(2000, bc, fh, hc, rs, fin, csl);
        check("t6_fin", fin, 1'b1);
        check("t6_busy_cyc", bc, 16);
        check("t6_pulses", rs, 8);
        rd_reg(STAT, v); check("t6_stat", v, 8'h02);
        rd_reg(DATA, v); check("t6_data", v, 8'h96);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
